// File: rtl/act_data_packer.sv
// ---------------------------------------------------------------------------
// act_data_packer
//
// Receiving end of the activation/quantization output stream. Packs
// BEATS_PER_WORD consecutive 8-lane feature beats into one wide write word,
// buffers completed words in a FIFO and drains them over a valid/ready
// handshake. A flush pulse emits a partially filled word (unfilled beats
// zero, beat mask marks the valid beats).
//
// Optional feature macro: ACT_PACKER_STATUS_EN
//   defined   -> overflow (sticky drop flag) and fifo_count are live
//   undefined -> overflow and fifo_count are tied to 0; dropping on a full
//                FIFO and almost_full work exactly the same
//
// Ports:
//   system_clk      in   clock
//   rst             in   asynchronous, active-high reset
//   act_data        in   one beat; lane i at [i*FEATURE_WIDTH +: FEATURE_WIDTH]
//   act_data_valid  in   beat qualifier, no backpressure
//   flush           in   single-cycle pulse, emits a partial word
//   wr_data         out  FIFO head word, beat 0 in the LSBs
//   wr_beat_mask    out  bit b set -> beat b of wr_data is valid
//   wr_data_valid   out  FIFO not empty
//   wr_data_ready   in   consumer accepts the head word
//   almost_full     out  free entries <= AF_MARGIN (registered)
//   overflow        out  sticky drop flag
//   fifo_count      out  words held
// ---------------------------------------------------------------------------
module act_data_packer #(
  parameter int FEATURE_WIDTH  = 16,
  parameter int BEATS_PER_WORD = 4,
  parameter int FIFO_DEPTH     = 16,
  parameter int AF_MARGIN      = 4
) (
  input  logic                                      system_clk,
  input  logic                                      rst,
  input  logic [FEATURE_WIDTH*8-1:0]                act_data,
  input  logic                                      act_data_valid,
  input  logic                                      flush,
  output logic [FEATURE_WIDTH*8*BEATS_PER_WORD-1:0] wr_data,
  output logic [BEATS_PER_WORD-1:0]                 wr_beat_mask,
  output logic                                      wr_data_valid,
  input  logic                                      wr_data_ready,
  output logic                                      almost_full,
  output logic                                      overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]           fifo_count
);

  localparam int BEAT_W = FEATURE_WIDTH * 8;
  localparam int WORD_W = BEAT_W * BEATS_PER_WORD;
  localparam int PCNT_W = $clog2(BEATS_PER_WORD);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  // -------------------------------------------------------------------------
  // Pack stage
  // -------------------------------------------------------------------------
  // Only BEATS_PER_WORD-1 beats are ever held: the last beat of a word goes
  // straight from act_data into the FIFO on the edge that completes it.
  logic [BEAT_W-1:0]         pack_q [BEATS_PER_WORD-1];
  logic [PCNT_W-1:0]         pcnt_q, pcnt_d;
  logic [PCNT_W:0]           fill;        // beats held after this cycle's beat
  logic                      beat_full;   // this beat completes a word
  logic                      push_req;    // a word (full or partial) is due
  logic [WORD_W-1:0]         push_word;
  logic [BEATS_PER_WORD-1:0] push_mask;

  // NOTE: every combinational output gets a default assignment at the top of
  // the block so no path can leave it unassigned and infer a latch.
  always_comb begin
    beat_full = 1'b0;
    fill      = {1'b0, pcnt_q} + (PCNT_W + 1)'(act_data_valid);
    push_req  = 1'b0;
    pcnt_d    = pcnt_q;
    push_mask = '0;

    beat_full = act_data_valid && (pcnt_q == PCNT_W'(BEATS_PER_WORD - 1));

    // The beat is counted first; a flush then emits whatever is held. When
    // the beat completes the word, the full push already covers the flush.
    push_req = beat_full || (flush && (fill != '0));

    for (int b = 0; b < BEATS_PER_WORD; b++) begin
      push_mask[b] = beat_full || ((PCNT_W + 1)'(b) < fill);
    end

    // Without a push, fill is at most BEATS_PER_WORD-1 and fits in pcnt.
    if (push_req) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = fill[PCNT_W-1:0];
    end
  end

  // Word assembly: slots not covered by the mask read as zero, so stale pack
  // contents never leak into a partial word.
  for (genvar g = 0; g < BEATS_PER_WORD; g++) begin : g_word
    if (g == BEATS_PER_WORD - 1) begin : g_last
      assign push_word[g*BEAT_W +: BEAT_W] = push_mask[g] ? act_data : '0;
    end else begin : g_held
      assign push_word[g*BEAT_W +: BEAT_W] =
        !push_mask[g]                                 ? '0       :
        (act_data_valid && (pcnt_q == PCNT_W'(g)))    ? act_data :
                                                        pack_q[g];
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Output FIFO
  // -------------------------------------------------------------------------
  logic [WORD_W-1:0]         mem_q      [FIFO_DEPTH];
  logic [BEATS_PER_WORD-1:0] mask_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      almost_full_q;
  logic                      fifo_full, fifo_empty;
  logic                      pop, do_push;

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign pop        = !fifo_empty && wr_data_ready;
  // A pop on the same edge frees the slot, so a push into a full FIFO still
  // lands when the consumer is draining.
  assign do_push    = push_req && (!fifo_full || pop);

  always_comb begin
    count_d = count_q;
    unique case ({do_push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: the storage arrays and the pack register carry no reset. Their
  // contents are only ever observed through the count and the beat mask,
  // both of which are reset, so clearing them would buy nothing.
  always_ff @(posedge system_clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q]      <= push_word;
      mask_mem_q[wr_ptr_q] <= push_mask;
    end
    for (int b = 0; b < BEATS_PER_WORD - 1; b++) begin
      if (act_data_valid && !beat_full && (pcnt_q == PCNT_W'(b))) begin
        pack_q[b] <= act_data;
      end
    end
  end

  // Pointers are exactly log2(FIFO_DEPTH) wide and wrap on their own.
  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      almost_full_q <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q       <= count_d;
      almost_full_q <= (CNT_W'(FIFO_DEPTH) - count_d) <= CNT_W'(AF_MARGIN);
    end
  end

  // The head is forced to zero while empty: this gives the zero reset value
  // and keeps the bus stable instead of showing unwritten storage.
  assign wr_data       = fifo_empty ? '0 : mem_q[rd_ptr_q];
  assign wr_beat_mask  = fifo_empty ? '0 : mask_mem_q[rd_ptr_q];
  assign wr_data_valid = !fifo_empty;
  assign almost_full   = almost_full_q;

  // -------------------------------------------------------------------------
  // Status outputs
  // -------------------------------------------------------------------------
`ifdef ACT_PACKER_STATUS_EN
  logic overflow_q;

  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (push_req && fifo_full && !pop) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow   = overflow_q;
  assign fifo_count = count_q;
`else
  assign overflow   = 1'b0;
  assign fifo_count = '0;
`endif

endmodule

// File: tb/tb_act_data_packer.sv
// ---------------------------------------------------------------------------
// tb_act_data_packer
//
// Directed bench for act_data_packer with default parameters. Inputs are
// driven and outputs sampled 1 ns after the rising edge. Expected words are
// built from lane-value formulas in the bench. Status outputs are expected
// live when ACT_PACKER_STATUS_EN is defined and zero otherwise.
// ---------------------------------------------------------------------------
module tb_act_data_packer;

  localparam int FW     = 16;
  localparam int BPW    = 4;
  localparam int DEPTH  = 16;
  localparam int BEAT_W = FW * 8;
  localparam int WORD_W = BEAT_W * BPW;

`ifdef ACT_PACKER_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  logic              system_clk = 1'b0;
  logic              rst;
  logic [BEAT_W-1:0] act_data;
  logic              act_data_valid;
  logic              flush;
  logic [WORD_W-1:0] wr_data;
  logic [BPW-1:0]    wr_beat_mask;
  logic              wr_data_valid;
  logic              wr_data_ready;
  logic              almost_full;
  logic              overflow;
  logic [4:0]        fifo_count;

  int checks_total  = 0;
  int checks_passed = 0;

  act_data_packer #(
    .FEATURE_WIDTH (FW),
    .BEATS_PER_WORD(BPW),
    .FIFO_DEPTH    (DEPTH),
    .AF_MARGIN     (4)
  ) dut (
    .system_clk    (system_clk),
    .rst           (rst),
    .act_data      (act_data),
    .act_data_valid(act_data_valid),
    .flush         (flush),
    .wr_data       (wr_data),
    .wr_beat_mask  (wr_beat_mask),
    .wr_data_valid (wr_data_valid),
    .wr_data_ready (wr_data_ready),
    .almost_full   (almost_full),
    .overflow      (overflow),
    .fifo_count    (fifo_count)
  );

  always #5 system_clk = ~system_clk;

  task automatic check(input string tag, input logic [WORD_W-1:0] obs,
                       input logic [WORD_W-1:0] exp);
    checks_total++;
    assert (obs === exp) begin
      checks_passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; returns 1 ns after the edge.
  task automatic cycle(input logic [BEAT_W-1:0] d, input logic v, input logic f);
    act_data       = d;
    act_data_valid = v;
    flush          = f;
    @(posedge system_clk);
    #1;
    act_data_valid = 1'b0;
    flush          = 1'b0;
  endtask

  // Lane i of beat k in tagged word w: {w, k, i}.
  function automatic logic [BEAT_W-1:0] beat_val(input int w, input int k);
    logic [BEAT_W-1:0] v;
    for (int i = 0; i < 8; i++) v[i*FW +: FW] = 16'((w << 8) | (k << 4) | i);
    return v;
  endfunction

  function automatic logic [WORD_W-1:0] word_val(input int w);
    logic [WORD_W-1:0] v;
    for (int k = 0; k < BPW; k++) v[k*BEAT_W +: BEAT_W] = beat_val(w, k);
    return v;
  endfunction

  // Counting pattern: lane i of beat k holds k*8+i+1 (0x0001..0x0020).
  function automatic logic [BEAT_W-1:0] cnt_beat(input int k);
    logic [BEAT_W-1:0] v;
    for (int i = 0; i < 8; i++) v[i*FW +: FW] = 16'(k * 8 + i + 1);
    return v;
  endfunction

  function automatic logic [WORD_W-1:0] cnt_word();
    logic [WORD_W-1:0] v;
    for (int j = 0; j < 32; j++) v[j*FW +: FW] = 16'(j + 1);
    return v;
  endfunction

  function automatic logic [4:0] exp_cnt(input int n);
    return STATUS_EN ? 5'(n) : 5'd0;
  endfunction

  initial begin
    logic [WORD_W-1:0] exp_word;

    rst            = 1'b1;
    act_data       = '0;
    act_data_valid = 1'b0;
    flush          = 1'b0;
    wr_data_ready  = 1'b0;
    repeat (2) @(posedge system_clk);
    #1;

    // ---- reset values ----
    check("rst_valid", wr_data_valid, 0);
    check("rst_mask",  wr_beat_mask,  0);
    check("rst_data",  wr_data,       0);
    check("rst_af",    almost_full,   0);
    check("rst_ovf",   overflow,      0);
    check("rst_count", fifo_count,    0);
    rst = 1'b0;

    // ---- four beats -> one full word, valid for exactly one cycle ----
    wr_data_ready = 1'b1;
    for (int k = 0; k < 3; k++) cycle(cnt_beat(k), 1'b1, 1'b0);
    check("t1_no_early_valid", wr_data_valid, 0);
    cycle(cnt_beat(3), 1'b1, 1'b0);
    check("t1_valid", wr_data_valid, 1);
    check("t1_data",  wr_data,       cnt_word());
    check("t1_mask",  wr_beat_mask,  4'b1111);
    check("t1_count", fifo_count,    exp_cnt(1));
    cycle('0, 1'b0, 1'b0);
    check("t1_valid_drop", wr_data_valid, 0);

    // ---- two beats then flush -> partial word ----
    cycle(beat_val(100, 0), 1'b1, 1'b0);
    cycle(beat_val(100, 1), 1'b1, 1'b0);
    cycle('0, 1'b0, 1'b1);
    exp_word = '0;
    exp_word[0 +: BEAT_W]      = beat_val(100, 0);
    exp_word[BEAT_W +: BEAT_W] = beat_val(100, 1);
    check("t2_valid", wr_data_valid, 1);
    check("t2_data",  wr_data,       exp_word);
    check("t2_mask",  wr_beat_mask,  4'b0011);
    cycle('0, 1'b0, 1'b0);
    check("t2_valid_drop", wr_data_valid, 0);

    // ---- flush with the 4th beat -> one full word only ----
    for (int k = 0; k < 3; k++) cycle(beat_val(101, k), 1'b1, 1'b0);
    cycle(beat_val(101, 3), 1'b1, 1'b1);
    check("t3_valid", wr_data_valid, 1);
    check("t3_data",  wr_data,       word_val(101));
    check("t3_mask",  wr_beat_mask,  4'b1111);
    cycle('0, 1'b0, 1'b0);
    check("t3_no_extra", wr_data_valid, 0);
    // flush with nothing packed -> no word
    cycle('0, 1'b0, 1'b1);
    check("t3_empty_flush", wr_data_valid, 0);
    cycle('0, 1'b0, 1'b0);
    check("t3_empty_flush2", wr_data_valid, 0);

    // ---- full FIFO, push and pop on the same edge ----
    wr_data_ready = 1'b0;
    for (int w = 21; w <= 36; w++)
      for (int k = 0; k < BPW; k++) cycle(beat_val(w, k), 1'b1, 1'b0);
    check("t5_full_count", fifo_count,  exp_cnt(16));
    check("t5_full_af",    almost_full, 1);
    for (int k = 0; k < 3; k++) cycle(beat_val(37, k), 1'b1, 1'b0);
    wr_data_ready = 1'b1;
    cycle(beat_val(37, 3), 1'b1, 1'b0);
    check("t5_count", fifo_count, exp_cnt(16));
    check("t5_ovf",   overflow,   0);
    for (int w = 22; w <= 37; w++) begin
      check("t5_drain_data", wr_data, word_val(w));
      @(posedge system_clk);
      #1;
    end
    check("t5_empty", wr_data_valid, 0);

    // ---- overflow: 68 beats into a stalled FIFO ----
    wr_data_ready = 1'b0;
    for (int w = 1; w <= 17; w++) begin
      for (int k = 0; k < BPW; k++) cycle(beat_val(w, k), 1'b1, 1'b0);
      if (w == 11) check("t4_af_at_11", almost_full, 0);
      if (w == 12) begin
        check("t4_af_at_12",    almost_full, 1);
        check("t4_count_at_12", fifo_count,  exp_cnt(12));
      end
      if (w == 16) check("t4_ovf_at_16", overflow, 0);
    end
    check("t4_ovf",   overflow,    STATUS_EN);
    check("t4_count", fifo_count,  exp_cnt(16));
    check("t4_af",    almost_full, 1);
    wr_data_ready = 1'b1;
    for (int w = 1; w <= 16; w++) begin
      check("t4_drain_valid", wr_data_valid, 1);
      check("t4_drain_data",  wr_data,       word_val(w));
      check("t4_drain_mask",  wr_beat_mask,  4'b1111);
      @(posedge system_clk);
      #1;
    end
    check("t4_empty",     wr_data_valid, 0);
    check("t4_af_clear",  almost_full,   0);
    check("t4_ovf_stick", overflow,      STATUS_EN);

    // ---- reset mid-word and mid-drain ----
    wr_data_ready = 1'b0;
    for (int w = 50; w <= 54; w++)
      for (int k = 0; k < BPW; k++) cycle(beat_val(w, k), 1'b1, 1'b0);
    cycle(beat_val(55, 0), 1'b1, 1'b0);
    cycle(beat_val(55, 1), 1'b1, 1'b0);
    check("t6_pre_count", fifo_count,    exp_cnt(5));
    check("t6_pre_valid", wr_data_valid, 1);
    rst = 1'b1;
    @(posedge system_clk);
    #1;
    check("t6_valid", wr_data_valid, 0);
    check("t6_mask",  wr_beat_mask,  0);
    check("t6_data",  wr_data,       0);
    check("t6_af",    almost_full,   0);
    check("t6_ovf",   overflow,      0);
    check("t6_count", fifo_count,    0);
    rst = 1'b0;
    wr_data_ready = 1'b1;
    for (int k = 0; k < BPW; k++) cycle(cnt_beat(k), 1'b1, 1'b0);
    check("t6_clean_valid", wr_data_valid, 1);
    check("t6_clean_data",  wr_data,       cnt_word());
    check("t6_clean_mask",  wr_beat_mask,  4'b1111);
    check("t6_clean_count", fifo_count,    exp_cnt(1));
    cycle('0, 1'b0, 1'b0);
    check("t6_clean_drop", wr_data_valid, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
